// File: rtl/adc_demo_pkg.sv
// Shared definitions for the ADC demo: ASCII constants and framer state encoding.
package adc_demo_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // SYNC waits for the transmitter to release complete before anything is sent.
  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } framer_state_t;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational map of a 4-bit value to its uppercase ASCII hex digit.
module hex_nibble_to_ascii
  import adc_demo_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0..9 map onto '0'..'9', 10..15 onto 'A'..'F'.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'd0, nibble};
    end else begin
      ascii = ASCII_A + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/adc_sample_hex_framer.sv
// Turns one ADC sample into an ASCII hex frame (optionally CR LF terminated)
// and feeds it byte by byte to the serial transmitter's request/complete handshake.
module adc_sample_hex_framer
  import adc_demo_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sampleValid,
  input  logic [SAMPLE_WIDTH-1:0] sampleData,
  output logic                    sampleReady,
  output logic [7:0]              txData,
  output logic                    txRequest,
  input  logic                    txComplete,
  output logic                    busy,
  output logic [7:0]              droppedCount
);

  localparam int         DIGITS     = (SAMPLE_WIDTH + 3) / 4;
  localparam int         HEX_W      = DIGITS * 4;
  localparam int         LAST_INDEX = DIGITS - 1 + 2 * int'(APPEND_CRLF);
  localparam logic [3:0] LAST_IDX   = 4'(LAST_INDEX);
  localparam logic [3:0] CR_IDX     = 4'(DIGITS);

  framer_state_t    state_q, state_d;
  logic [HEX_W-1:0] sample_q, sample_d;
  logic [3:0]       char_idx_q, char_idx_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [3:0]       nib_arr [DIGITS];
  logic [3:0]       nibble_sel;
  logic [7:0]       hex_char;
  logic [7:0]       char_byte;

  // Split the (next) captured sample into digits, most significant first.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_arr[gi] = sample_d[4*(DIGITS-1-gi) +: 4];
  end

  // Pick the digit addressed by the next character index.
  always_comb begin
    nibble_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (char_idx_d == 4'(i)) nibble_sel = nib_arr[i];
    end
  end

  hex_nibble_to_ascii u_hex (
    .nibble (nibble_sel),
    .ascii  (hex_char)
  );

  // Character for the next index: hex digit, then CR, then LF.
  always_comb begin
    if (char_idx_d < CR_IDX) begin
      char_byte = hex_char;
    end else if (char_idx_d == CR_IDX) begin
      char_byte = ASCII_CR;
    end else begin
      char_byte = ASCII_LF;
    end
  end

  // Next-state, capture and drop-counter logic.
  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    char_idx_d = char_idx_q;
    dropped_d  = dropped_q;
    unique case (state_q)
      SYNC: begin
        if (!txComplete) state_d = IDLE;
      end
      IDLE: begin
        if (sampleValid) begin
          sample_d   = HEX_W'(sampleData);
          char_idx_d = 4'd0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (txComplete) state_d = RELEASE;
      end
      RELEASE: begin
        if (!txComplete) begin
          if (char_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx_q + 4'd1;
            state_d    = REQ;
          end
        end
      end
      default: state_d = SYNC;
    endcase
    // Samples offered while not ready are rejected; SYNC rejects silently.
    if (sampleValid && !ready_q && (state_q != SYNC) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  // Outputs are registered decodes of the next state so they change on the deciding edge.
  always_comb begin
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    tx_req_d  = (state_d == REQ);
    tx_data_d = tx_req_d ? char_byte : tx_data_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SYNC;
      sample_q   <= '0;
      char_idx_q <= 4'd0;
      dropped_q  <= 8'd0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      char_idx_q <= char_idx_d;
      dropped_q  <= dropped_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign sampleReady  = ready_q;
  assign txData       = tx_data_q;
  assign txRequest    = tx_req_q;
  assign busy         = busy_q;
  assign droppedCount = dropped_q;

endmodule

// File: tb/tb_adc_sample_hex_framer.sv
// Bench for adc_sample_hex_framer: two instances (12-bit with CR LF, 10-bit digits only)
// each driven by a behavioural transmitter with configurable complete delay and hold.
module tb_adc_sample_hex_framer;

  logic       clk = 1'b0;
  logic       srst;
  logic       a_valid;
  logic [11:0] a_data;
  logic       b_valid;
  logic [9:0] b_data;

  logic       req [2];
  logic [7:0] txd [2];
  logic       cmp [2] = '{1'b1, 1'b0};
  logic       rdy [2];
  logic       bsy [2];
  logic [7:0] drp [2];

  int dly  [2];
  int hold [2];
  int wcnt [2] = '{0, 0};
  int hcnt [2] = '{0, 0};
  int nbytes [2] = '{0, 0};
  logic       req_prev  [2] = '{1'b0, 1'b0};
  logic [7:0] data_prev [2] = '{8'h00, 8'h00};

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  int n_cmp = 0;
  int n_bad = 0;
  int tgt [2] = '{0, 0};

  always #5 clk = ~clk;

  adc_sample_hex_framer #(.SAMPLE_WIDTH(12), .APPEND_CRLF(1'b1)) u_dut_a (
    .clock        (clk),
    .reset        (srst),
    .sampleValid  (a_valid),
    .sampleData   (a_data),
    .sampleReady  (rdy[0]),
    .txData       (txd[0]),
    .txRequest    (req[0]),
    .txComplete   (cmp[0]),
    .busy         (bsy[0]),
    .droppedCount (drp[0])
  );

  adc_sample_hex_framer #(.SAMPLE_WIDTH(10), .APPEND_CRLF(1'b0)) u_dut_b (
    .clock        (clk),
    .reset        (srst),
    .sampleValid  (b_valid),
    .sampleData   (b_data),
    .sampleReady  (rdy[1]),
    .txData       (txd[1]),
    .txRequest    (req[1]),
    .txComplete   (cmp[1]),
    .busy         (bsy[1]),
    .droppedCount (drp[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [31:0] v, input int digits, input int i);
    logic [31:0] nib;
    if (i < digits) begin
      nib = (v >> (4 * (digits - 1 - i))) & 32'hF;
      if (nib < 10) return 8'h30 + 8'(nib);
      return 8'h41 + 8'(nib - 10);
    end
    if (i == digits) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_frame(input int k, input logic [31:0] v, input int digits, input bit crlf);
    int n;
    n = digits + (crlf ? 2 : 0);
    for (int i = 0; i < n; i++) begin
      if (k == 0) exp_q0.push_back(exp_char(v, digits, i));
      else        exp_q1.push_back(exp_char(v, digits, i));
    end
    tgt[k] += n;
  endtask

  task automatic got_byte(input int k, input logic [7:0] b);
    logic [7:0] e;
    if (qsize(k) == 0) begin
      check_eq($sformatf("dut%0d_unexpected_byte", k), {24'd0, b}, 32'hFFFF_FFFF);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_eq($sformatf("dut%0d_byte", k), {24'd0, b}, {24'd0, e});
      $display("dut%0d byte 0x%02h expected 0x%02h", k, b, e);
    end
  endtask

  // Behavioural transmitter: complete rises dly cycles into a request, is held for hold cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (req[k] && !req_prev[k]) check_eq($sformatf("dut%0d_req_rise_while_cmp", k), {31'd0, cmp[k]}, 32'd0);
      if (req[k] && req_prev[k])  check_eq($sformatf("dut%0d_data_stable", k), {24'd0, txd[k]}, {24'd0, data_prev[k]});
      req_prev[k]  = req[k];
      data_prev[k] = txd[k];
      if (cmp[k]) begin
        if (hcnt[k] >= hold[k]) begin
          cmp[k]  = 1'b0;
          hcnt[k] = 0;
        end else begin
          hcnt[k]++;
        end
      end else if (req[k]) begin
        if (wcnt[k] >= dly[k]) begin
          wcnt[k] = 0;
          cmp[k]  = 1'b1;
          nbytes[k]++;
          got_byte(k, txd[k]);
        end else begin
          wcnt[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input int k, input int budget);
    int n;
    n = 0;
    while (!(nbytes[k] == tgt[k] && rdy[k]) && n < budget) begin
      tick();
      n++;
    end
    check_eq($sformatf("dut%0d_frame_done", k), {31'd0, (nbytes[k] == tgt[k] && rdy[k])}, 32'd1);
    check_eq($sformatf("dut%0d_idle_busy", k), {31'd0, bsy[k]}, 32'd0);
    check_eq($sformatf("dut%0d_queue_empty", k), qsize(k), 32'd0);
  endtask

  task automatic send_a(input logic [11:0] v);
    a_data  = v;
    a_valid = 1'b1;
    push_frame(0, {20'd0, v}, 3, 1'b1);
    tick();
    a_valid = 1'b0;
    check_eq("a_lat_req", {31'd0, req[0]}, 32'd1);
    check_eq("a_lat_data", {24'd0, txd[0]}, {24'd0, exp_char({20'd0, v}, 3, 0)});
    check_eq("a_lat_ready", {31'd0, rdy[0]}, 32'd0);
    $display("dut0 sample 0x%03h accepted", v);
  endtask

  task automatic send_b(input logic [9:0] v);
    b_data  = v;
    b_valid = 1'b1;
    push_frame(1, {22'd0, v}, 3, 1'b0);
    tick();
    b_valid = 1'b0;
    check_eq("b_lat_req", {31'd0, req[1]}, 32'd1);
    check_eq("b_lat_data", {24'd0, txd[1]}, {24'd0, exp_char({22'd0, v}, 3, 0)});
    $display("dut1 sample 0x%03h accepted", v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    srst    = 1'b1;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    dly     = '{2, 2};
    hold    = '{10, 1};
    repeat (3) tick();
    check_eq("rst_req", {31'd0, req[0]}, 32'd0);
    check_eq("rst_data", {24'd0, txd[0]}, 32'd0);
    check_eq("rst_ready", {31'd0, rdy[0]}, 32'd0);
    check_eq("rst_busy", {31'd0, bsy[0]}, 32'd1);
    check_eq("rst_dropped", {24'd0, drp[0]}, 32'd0);
    srst = 1'b0;

    // complete still high from before reset: stay in SYNC, ignore and do not count samples
    a_valid = 1'b1;
    a_data  = 12'hFFF;
    repeat (2) tick();
    a_valid = 1'b0;
    check_eq("sync_cmp_still_high", {31'd0, cmp[0]}, 32'd1);
    check_eq("sync_ready", {31'd0, rdy[0]}, 32'd0);
    check_eq("sync_busy", {31'd0, bsy[0]}, 32'd1);
    check_eq("sync_no_count", {24'd0, drp[0]}, 32'd0);
    check_eq("sync_no_req", {31'd0, req[0]}, 32'd0);
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 50) begin tick(); n++; end
    check_eq("sync_exit", {31'd0, rdy[0] && rdy[1]}, 32'd1);

    // basic frame
    hold[0] = 1;
    send_a(12'hA5C);
    wait_frame(0, 500);
    check_eq("basic_5_bytes", nbytes[0], 32'd5);

    // long complete hold stresses request discipline
    hold[0] = 20;
    send_a(12'h7E9);
    wait_frame(0, 1000);

    // 10-bit, digits only
    send_b(10'h3FF);
    wait_frame(1, 500);
    send_b(10'h000);
    wait_frame(1, 500);
    check_eq("b_bytes", nbytes[1], 32'd6);

    // drops while busy: 300 cycles of valid, only the first is framed
    dly[0]  = 70;
    hold[0] = 5;
    a_data  = 12'h5B0;
    a_valid = 1'b1;
    push_frame(0, 32'h5B0, 3, 1'b1);
    for (int i = 1; i < 300; i++) begin
      tick();
      a_data = 12'($urandom);
    end
    tick();
    a_valid = 1'b0;
    check_eq("drop_saturate", {24'd0, drp[0]}, 32'd255);
    check_eq("drop_still_busy", {31'd0, bsy[0]}, 32'd1);
    wait_frame(0, 2000);
    check_eq("drop_saturate_held", {24'd0, drp[0]}, 32'd255);

    // reset during second character while complete is high
    dly[0]  = 2;
    hold[0] = 20;
    send_a(12'hA5C);
    n = 0;
    while (nbytes[0] < tgt[0] - 3 && n < 200) begin tick(); n++; end
    check_eq("rst_mid_reached", {31'd0, cmp[0]}, 32'd1);
    srst = 1'b1;
    exp_q0.delete();
    tgt[0] = nbytes[0];
    tick();
    srst = 1'b0;
    check_eq("rst_mid_req_low", {31'd0, req[0]}, 32'd0);
    check_eq("rst_mid_dropped_clr", {24'd0, drp[0]}, 32'd0);
    n = 0;
    while (cmp[0] && n < 40) begin
      check_eq("rst_mid_ready_low", {31'd0, rdy[0]}, 32'd0);
      check_eq("rst_mid_no_req", {31'd0, req[0]}, 32'd0);
      tick();
      n++;
    end
    check_eq("rst_mid_cmp_fell", {31'd0, cmp[0]}, 32'd0);
    n = 0;
    while (!rdy[0] && n < 10) begin tick(); n++; end
    check_eq("rst_mid_recovered", {31'd0, rdy[0]}, 32'd1);

    // recovery frame
    hold[0] = 1;
    send_a(12'h123);
    wait_frame(0, 500);
    check_eq("recover_dropped", {24'd0, drp[0]}, 32'd0);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
